// File: rtl/painterengine_gpu_dma_reader.sv
// painterengine_gpu_dma_reader: AXI4 read master streaming a contiguous word block into the GPU FIFO.
// Rev 1.0
`default_nettype none

module painterengine_gpu_dma_reader #(
   parameter int unsigned C_MAX_BURST = 16
) (
   input  logic        i_wire_clock,
   input  logic        i_wire_resetn,
   input  logic [31:0] i_wire_address,
   input  logic [31:0] i_wire_length,
   output logic        o_wire_done,
   output logic        o_wire_error,
   output logic [31:0] o_wire_fifo_wdata,
   output logic        o_wire_fifo_wen,
   input  logic        i_wire_fifo_full,
   output logic [31:0] o_wire_m_axi_araddr,
   output logic [7:0]  o_wire_m_axi_arlen,
   output logic [2:0]  o_wire_m_axi_arsize,
   output logic [1:0]  o_wire_m_axi_arburst,
   output logic        o_wire_m_axi_arvalid,
   input  logic        i_wire_m_axi_arready,
   input  logic [31:0] i_wire_m_axi_rdata,
   input  logic [1:0]  i_wire_m_axi_rresp,
   input  logic        i_wire_m_axi_rlast,
   input  logic        i_wire_m_axi_rvalid,
   output logic        o_wire_m_axi_rready
);

   typedef enum logic [2:0] {
      RESET_IDLE = 3'd0,
      CHECK      = 3'd1,
      CALC       = 3'd2,
      ADDR       = 3'd3,
      DATA       = 3'd4,
      DONE       = 3'd5,
      ERROR      = 3'd6
   } state_t;

   state_t      state;
   logic [31:0] addr;
   logic [31:0] remaining;
   logic [8:0]  beat_cnt;
   logic [31:0] span;
   logic [31:0] beats;
   logic        accept;
   logic        last_beat;

   // Burst size is the smallest of what is left, the burst cap and the room before the next 4 KB page.
   always_comb begin
      span  = (32'd4096 - {20'd0, addr[11:0]}) >> 2;
      beats = remaining;
      if (beats > C_MAX_BURST) beats = C_MAX_BURST;
      if (beats > span) beats = span;
   end

   assign o_wire_m_axi_arsize  = 3'b010;
   assign o_wire_m_axi_arburst = 2'b01;
   assign o_wire_fifo_wdata    = i_wire_m_axi_rdata;

   // In ERROR the R channel is drained unconditionally so the shared interconnect is left idle.
   assign o_wire_m_axi_rready = ((state == DATA) && !i_wire_fifo_full) || (state == ERROR);
   assign accept              = i_wire_m_axi_rvalid && o_wire_m_axi_rready;
   assign o_wire_fifo_wen     = (state == DATA) && accept && (i_wire_m_axi_rresp == 2'b00);
   assign last_beat           = (beat_cnt == 9'd1);

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state                <= RESET_IDLE;
         addr                 <= 32'd0;
         remaining            <= 32'd0;
         beat_cnt             <= 9'd0;
         o_wire_done          <= 1'b0;
         o_wire_error         <= 1'b0;
         o_wire_m_axi_araddr  <= 32'd0;
         o_wire_m_axi_arlen   <= 8'd0;
         o_wire_m_axi_arvalid <= 1'b0;
      end else begin
         case (state)
            RESET_IDLE: state <= CHECK;
            CHECK: begin
               addr      <= i_wire_address;
               remaining <= i_wire_length;
               if (i_wire_address[1:0] != 2'b00) begin
                  state        <= ERROR;
                  o_wire_error <= 1'b1;
               end else if (i_wire_length == 32'd0) begin
                  state       <= DONE;
                  o_wire_done <= 1'b1;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               o_wire_m_axi_araddr  <= addr;
               o_wire_m_axi_arlen   <= 8'(beats - 32'd1);
               o_wire_m_axi_arvalid <= 1'b1;
               state                <= ADDR;
            end
            ADDR: begin
               if (i_wire_m_axi_arready) begin
                  o_wire_m_axi_arvalid <= 1'b0;
                  beat_cnt             <= {1'b0, o_wire_m_axi_arlen} + 9'd1;
                  state                <= DATA;
               end
            end
            DATA: begin
               if (accept) begin
                  beat_cnt  <= beat_cnt - 9'd1;
                  remaining <= remaining - 32'd1;
                  addr      <= addr + 32'd4;
                  if ((i_wire_m_axi_rresp != 2'b00) || (i_wire_m_axi_rlast != last_beat)) begin
                     state        <= ERROR;
                     o_wire_error <= 1'b1;
                  end else if (last_beat) begin
                     if (remaining != 32'd1) begin
                        state <= CALC;
                     end else begin
                        state       <= DONE;
                        o_wire_done <= 1'b1;
                     end
                  end
               end
            end
            DONE:    state <= DONE;
            ERROR:   state <= ERROR;
            default: state <= RESET_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_painterengine_gpu_dma_reader.sv
// tb_painterengine_gpu_dma_reader: directed checks of the DMA reader against a simple AXI read slave.
// Rev 1.0
`default_nettype none

module tb_painterengine_gpu_dma_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] address, length;
   logic        done, error;
   logic [31:0] fifo_wdata;
   logic        fifo_wen, fifo_full;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;

   int vectors = 0;
   int miscompares = 0;

   // Slave model state
   int          err_beat;
   bit          no_rlast;
   int          gbeat;
   bit          in_burst;
   logic [31:0] baddr;
   int          bleft;
   logic [31:0] ar_addr_q[$];
   logic [7:0]  ar_len_q[$];
   logic [31:0] wr_q[$];

   always #5 clk = ~clk;

   painterengine_gpu_dma_reader #(.C_MAX_BURST(16)) dut (
      .i_wire_clock         (clk),
      .i_wire_resetn        (rst_n),
      .i_wire_address       (address),
      .i_wire_length        (length),
      .o_wire_done          (done),
      .o_wire_error         (error),
      .o_wire_fifo_wdata    (fifo_wdata),
      .o_wire_fifo_wen      (fifo_wen),
      .i_wire_fifo_full     (fifo_full),
      .o_wire_m_axi_araddr  (araddr),
      .o_wire_m_axi_arlen   (arlen),
      .o_wire_m_axi_arsize  (arsize),
      .o_wire_m_axi_arburst (arburst),
      .o_wire_m_axi_arvalid (arvalid),
      .i_wire_m_axi_arready (arready),
      .i_wire_m_axi_rdata   (rdata),
      .i_wire_m_axi_rresp   (rresp),
      .i_wire_m_axi_rlast   (rlast),
      .i_wire_m_axi_rvalid  (rvalid),
      .o_wire_m_axi_rready  (rready)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_slave();
      rvalid = in_burst;
      rdata  = mem(baddr);
      rlast  = in_burst && (bleft == 1) && !no_rlast;
      rresp  = (in_burst && (gbeat + 1 == err_beat)) ? 2'b10 : 2'b00;
   endtask

   // Handshakes are captured at the edge, the slave responds 1 ns later.
   always @(posedge clk) begin
      bit          ar_fire, r_fire, wen_s;
      logic [31:0] wd, aa;
      logic [7:0]  al;
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      wen_s   = fifo_wen;
      wd      = fifo_wdata;
      aa      = araddr;
      al      = arlen;
      #1;
      if (wen_s) wr_q.push_back(wd);
      if (r_fire && in_burst) begin
         baddr = baddr + 32'd4;
         bleft--;
         gbeat++;
         if (bleft == 0) in_burst = 1'b0;
      end
      if (ar_fire) begin
         ar_addr_q.push_back(aa);
         ar_len_q.push_back(al);
         in_burst = 1'b1;
         baddr    = aa;
         bleft    = int'(al) + 1;
      end
      drive_slave();
   end

   task automatic start_run(input logic [31:0] a, input logic [31:0] l);
      @(negedge clk);
      rst_n    = 1'b0;
      in_burst = 1'b0;
      gbeat    = 0;
      bleft    = 0;
      baddr    = 32'd0;
      ar_addr_q.delete();
      ar_len_q.delete();
      wr_q.delete();
      drive_slave();
      address = a;
      length  = l;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_end(input string tag);
      int n = 0;
      while (!(done || error) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(done || error), 32'd1);
   endtask

   task automatic wait_writes(input string tag, input int cnt);
      int n = 0;
      while (wr_q.size() < cnt && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(wr_q.size() >= cnt), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      fifo_full = 1'b0;
      arready   = 1'b1;
      address   = 32'd0;
      length    = 32'd0;
      err_beat  = 0;
      no_rlast  = 1'b0;
      in_burst  = 1'b0;
      gbeat     = 0;
      bleft     = 0;
      baddr     = 32'd0;
      drive_slave();
      repeat (2) @(negedge clk);

      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_arvalid", 32'(arvalid), 32'd0);
      check("rst_rready", 32'(rready), 32'd0);
      check("rst_wen", 32'(fifo_wen), 32'd0);
      check("rst_araddr", araddr, 32'd0);
      check("rst_arlen", 32'(arlen), 32'd0);
      check("arsize", 32'(arsize), 32'd2);
      check("arburst", 32'(arburst), 32'd1);

      // Two full bursts
      start_run(32'h1000, 32'd32);
      repeat (2) @(negedge clk);
      check("t1_arvalid_e2", 32'(arvalid), 32'd0);
      @(negedge clk);
      check("t1_arvalid_e3", 32'(arvalid), 32'd1);
      wait_end("t1_end");
      check("t1_done", 32'(done), 32'd1);
      check("t1_error", 32'(error), 32'd0);
      check("t1_ar_cnt", 32'(ar_addr_q.size()), 32'd2);
      check("t1_ar0_addr", ar_addr_q[0], 32'h1000);
      check("t1_ar0_len", 32'(ar_len_q[0]), 32'd15);
      check("t1_ar1_addr", ar_addr_q[1], 32'h1040);
      check("t1_ar1_len", 32'(ar_len_q[1]), 32'd15);
      check("t1_wr_cnt", 32'(wr_q.size()), 32'd32);
      for (int i = 0; i < 32; i++) check("t1_data", wr_q[i], mem(32'h1000 + 32'(i * 4)));

      // 4 KB boundary split
      start_run(32'h1FF8, 32'd8);
      wait_end("t2_end");
      check("t2_done", 32'(done), 32'd1);
      check("t2_ar_cnt", 32'(ar_addr_q.size()), 32'd2);
      check("t2_ar0_addr", ar_addr_q[0], 32'h1FF8);
      check("t2_ar0_len", 32'(ar_len_q[0]), 32'd1);
      check("t2_ar1_addr", ar_addr_q[1], 32'h2000);
      check("t2_ar1_len", 32'(ar_len_q[1]), 32'd5);
      check("t2_wr_cnt", 32'(wr_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) check("t2_data", wr_q[i], mem(32'h1FF8 + 32'(i * 4)));

      // FIFO backpressure mid-burst
      start_run(32'h3000, 32'd4);
      wait_writes("t3_wait", 2);
      fifo_full = 1'b1;
      repeat (3) begin
         #1;
         check("t3_rready_full", 32'(rready), 32'd0);
         check("t3_wen_full", 32'(fifo_wen), 32'd0);
         @(negedge clk);
      end
      check("t3_wr_hold", 32'(wr_q.size()), 32'd2);
      fifo_full = 1'b0;
      wait_end("t3_end");
      check("t3_done", 32'(done), 32'd1);
      check("t3_wr_cnt", 32'(wr_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) check("t3_data", wr_q[i], mem(32'h3000 + 32'(i * 4)));

      // Error response on beat 3
      err_beat = 3;
      start_run(32'h4000, 32'd8);
      wait_end("t4_end");
      repeat (12) @(negedge clk);
      check("t4_error", 32'(error), 32'd1);
      check("t4_done", 32'(done), 32'd0);
      check("t4_wr_cnt", 32'(wr_q.size()), 32'd2);
      check("t4_ar_cnt", 32'(ar_addr_q.size()), 32'd1);
      check("t4_drained", 32'(in_burst), 32'd0);
      check("t4_rready", 32'(rready), 32'd1);
      check("t4_arvalid", 32'(arvalid), 32'd0);
      err_beat = 0;

      // Zero length
      start_run(32'h5000, 32'd0);
      @(negedge clk);
      check("t5_done_e1", 32'(done), 32'd0);
      @(negedge clk);
      check("t5_done_e2", 32'(done), 32'd1);
      repeat (4) @(negedge clk);
      check("t5_ar_cnt", 32'(ar_addr_q.size()), 32'd0);
      check("t5_error", 32'(error), 32'd0);

      // Misaligned address
      start_run(32'h1002, 32'd4);
      wait_end("t6_end");
      repeat (4) @(negedge clk);
      check("t6_error", 32'(error), 32'd1);
      check("t6_done", 32'(done), 32'd0);
      check("t6_ar_cnt", 32'(ar_addr_q.size()), 32'd0);

      // Missing rlast on final beat
      no_rlast = 1'b1;
      start_run(32'h5000, 32'd4);
      wait_end("t7_end");
      check("t7_error", 32'(error), 32'd1);
      check("t7_done", 32'(done), 32'd0);
      no_rlast = 1'b0;

      // Reset asserted mid-burst, then a fresh run
      start_run(32'h6000, 32'd16);
      wait_writes("t8_wait", 2);
      rst_n = 1'b0;
      #1;
      check("t8_arvalid", 32'(arvalid), 32'd0);
      check("t8_rready", 32'(rready), 32'd0);
      check("t8_wen", 32'(fifo_wen), 32'd0);
      check("t8_done", 32'(done), 32'd0);
      check("t8_error", 32'(error), 32'd0);
      start_run(32'h7000, 32'd2);
      wait_end("t8_end");
      check("t8_done2", 32'(done), 32'd1);
      check("t8_ar_cnt", 32'(ar_addr_q.size()), 32'd1);
      check("t8_ar_addr", ar_addr_q[0], 32'h7000);
      check("t8_ar_len", 32'(ar_len_q[0]), 32'd1);
      check("t8_wr_cnt", 32'(wr_q.size()), 32'd2);
      check("t8_data0", wr_q[0], mem(32'h7000));
      check("t8_data1", wr_q[1], mem(32'h7004));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
